// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam logic [7:0] IO_ADDR_DEFAULT = 8'h01;

endpackage

// File: rtl/dmem_io_reg.sv
// Memory-mapped output register: captures any performed write to IO_ADDR
// and pulses io_out_valid_o for the following cycle.
module dmem_io_reg
  import dmem_pkg::*;
#(
  parameter int unsigned   AW      = 8,
  parameter int unsigned   DW      = 8,
  parameter logic [AW-1:0] IO_ADDR = AW'(IO_ADDR_DEFAULT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] io_out_o,
  output logic          io_out_valid_o
);

  logic          hit;
  logic [DW-1:0] io_q, io_d;
  logic          vld_q, vld_d;

  always_comb begin
    hit   = wr_en_i && (addr_i == IO_ADDR);
    io_d  = hit ? data_i : io_q;
    vld_d = hit;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      io_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      io_q  <= io_d;
      vld_q <= vld_d;
    end
  end

  assign io_out_o       = io_q;
  assign io_out_valid_o = vld_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU has priority, the debug port gets
// idle cycles or a forced bounded burst after STARVE_LIMIT busy cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned   AW            = 8,
  parameter int unsigned   DW            = 8,
  parameter logic [AW-1:0] IO_ADDR       = AW'(IO_ADDR_DEFAULT),
  parameter int unsigned   DBG_MAX_BURST = 4,
  parameter int unsigned   STARVE_LIMIT  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_wr,
  input  logic [DW-1:0] cpu_wr_data,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rd_data,
  output logic          cpu_rd_valid,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  input  logic          dbg_wr,
  input  logic [DW-1:0] dbg_wr_data,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_rd_data,
  output logic          dbg_rd_valid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data,
  output logic [DW-1:0] io_out,
  output logic          io_out_valid
);

  localparam int unsigned   SW          = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned   BW          = $clog2(DBG_MAX_BURST + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
  localparam logic [BW-1:0] BURST_LAST  = BW'(DBG_MAX_BURST - 1);

  owner_e        owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          rd_pend_q, rd_pend_d;
  owner_e        rd_tag_q, rd_tag_d;
  logic          cpu_go, dbg_go;

  always_comb begin
    owner_d     = owner_q;
    starve_d    = starve_q;
    burst_d     = burst_q;
    cpu_go      = 1'b0;
    dbg_go      = 1'b0;
    cpu_stall   = 1'b0;
    dbg_gnt     = 1'b0;
    mem_addr    = cpu_addr;
    mem_wr_data = cpu_wr_data;
    mem_wr      = 1'b0;
    rd_tag_d    = owner_q;

    unique case (owner_q)
      OWN_CPU: begin
        cpu_go = cpu_req;
        mem_wr = cpu_req && cpu_wr;
        if (dbg_req && (!cpu_req || starve_q == STARVE_LAST)) begin
          owner_d  = OWN_DBG;
          starve_d = '0;
        end else if (!dbg_req) begin
          starve_d = '0;
        end else begin
          starve_d = starve_q + 1'b1;
        end
      end
      OWN_DBG: begin
        dbg_go      = dbg_req;
        dbg_gnt     = dbg_req;
        cpu_stall   = cpu_req;
        mem_addr    = dbg_addr;
        mem_wr_data = dbg_wr_data;
        mem_wr      = dbg_req && dbg_wr;
        if (!dbg_req) begin
          owner_d = OWN_CPU;
          burst_d = '0;
        end else if (burst_q == BURST_LAST) begin
          // An idle CPU lets the debug port start a fresh burst in place.
          burst_d = '0;
          if (cpu_req) owner_d = OWN_CPU;
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end
    endcase

    rd_pend_d = (cpu_go && !cpu_wr) || (dbg_go && !dbg_wr);

    if (!rst) begin
      mem_wr    = 1'b0;
      dbg_gnt   = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q   <= OWN_CPU;
      starve_q  <= '0;
      burst_q   <= '0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= OWN_CPU;
    end else begin
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      burst_q   <= burst_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  assign cpu_rd_valid = rd_pend_q && (rd_tag_q == OWN_CPU);
  assign dbg_rd_valid = rd_pend_q && (rd_tag_q == OWN_DBG);
  assign cpu_rd_data  = mem_rd_data;
  assign dbg_rd_data  = mem_rd_data;

  dmem_io_reg #(
    .AW      (AW),
    .DW      (DW),
    .IO_ADDR (IO_ADDR)
  ) u_io_reg (
    .clk_i          (clk),
    .rst_ni         (rst),
    .wr_en_i        (mem_wr),
    .addr_i         (mem_addr),
    .data_i         (mem_wr_data),
    .io_out_o       (io_out),
    .io_out_valid_o (io_out_valid)
  );

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port, 256×8 data memory between the CPU and a debug/loader requester, and decodes the memory-mapped output register at `IO_ADDR`. It sits between `cpu` and the data memory array. It multiplexes address, write and write data onto the memory port, and routes the 1-cycle-latency read data back to the owning requester with a valid strobe. CPU has priority; the debug port is served when the CPU is idle, or forcibly after a bounded starvation interval.

## Interface
- `AW`, 8, address width
- `DW`, 8, data width
- `IO_ADDR`, 8'h01, address of the output register
- `DBG_MAX_BURST`, 4, maximum consecutive debug accesses per grant (≥1)
- `STARVE_LIMIT`, 8, consecutive CPU-owned cycles with `dbg_req` pending before the debug port is forced in (≥1)
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  reset, synchronous, active-low
- `cpu_req`  in  1  CPU requests a memory access this cycle
- `cpu_addr`  in  AW  CPU address
- `cpu_wr`  in  1  CPU write enable (qualified by `cpu_req`)
- `cpu_wr_data`  in  DW  CPU write data
- `cpu_stall`  out  1  CPU access not performed this cycle; hold request
- `cpu_rd_data`  out  DW  read data (valid with `cpu_rd_valid`)
- `cpu_rd_valid`  out  1  pulse, one cycle after a granted CPU read
- `dbg_req`  in  1  debug requests an access
- `dbg_addr`  in  AW  debug address
- `dbg_wr`  in  1  debug write enable
- `dbg_wr_data`  in  DW  debug write data
- `dbg_gnt`  out  1  debug access performed this cycle
- `dbg_rd_data`  out  DW  read data (valid with `dbg_rd_valid`)
- `dbg_rd_valid`  out  1  pulse, one cycle after a granted debug read
- `mem_addr`  out  AW  memory address
- `mem_wr`  out  1  memory write enable
- `mem_wr_data`  out  DW  memory write data
- `mem_rd_data`  in  DW  memory read data, registered in memory (1-cycle latency)
- `io_out`  out  DW  last value written to `IO_ADDR`
- `io_out_valid`  out  1  pulse, one cycle after any granted write to `IO_ADDR`

## Operation
- Owner state register: `OWN_CPU` / `OWN_DBG`. Memory port is driven combinationally from the current owner's inputs.
- `OWN_CPU`: `cpu_stall`=0, `dbg_gnt`=0. If `cpu_req`=0, `mem_wr`=0 and `mem_addr`=`cpu_addr`.
- `OWN_CPU` → `OWN_DBG` when `dbg_req` && (!`cpu_req` || `starve_cnt`==`STARVE_LIMIT`-1). The debug access occurs the cycle after the decision.
- `starve_cnt`: increments in `OWN_CPU` when `cpu_req`&&`dbg_req`. Clears when `dbg_req`=0 or on leaving `OWN_CPU`.
- `OWN_DBG`: `dbg_gnt`=`dbg_req`. `cpu_stall`=`cpu_req`. `burst_cnt` increments per granted access.
- `OWN_DBG` → `OWN_CPU` when !`dbg_req`, or when `burst_cnt`==`DBG_MAX_BURST`-1 on a granted access and `cpu_req`=1.
  - If the burst ends with `cpu_req`=0 and `dbg_req`=1: stay in `OWN_DBG` and clear `burst_cnt`.
- Read routing: a 1-bit owner tag and a read-pending flag are registered per granted read. Next cycle, the tagged requester's `*_rd_valid`=1; both `*_rd_data` = `mem_rd_data`.
- IO decode: a granted write with address==`IO_ADDR` (either owner) also writes memory. `io_out` is loaded with the write data at the same edge; `io_out_valid`=1 for the following cycle only.

## Timing
- Reset (rst=0 at posedge):
  - owner=`OWN_CPU`; counters=0; `io_out`=0.
  - `io_out_valid`=0; both `rd_valid`=0; pending read dropped.
  - While rst=0: `mem_wr`=0, `dbg_gnt`=0, `cpu_stall`=0.
- Reset mid-burst aborts the burst. No write is issued in a reset cycle.
- Read latency: data and valid arrive exactly 1 cycle after the granted cycle. Back-to-back reads give valid every cycle.
- Debug grant latency from `dbg_req` rise: 2 cycles when the CPU is idle. At most `STARVE_LIMIT`+1 cycles when the CPU is busy.
- The CPU waits at most `DBG_MAX_BURST` cycles of stall per debug grant.
- Handover: the owner change takes effect at the edge. No idle cycle is inserted and no access is granted twice.

## Structure
- `dmem_pkg`: `owner_e` enum (`OWN_CPU`, `OWN_DBG`) and default `IO_ADDR` constant.
- Optional sub-module `dmem_io_reg`: `io_out`/`io_out_valid` capture. The arbiter FSM, counters and read tag stay in `dmem_arbiter`.

## Test plan
- CPU-only: write 8'h5A to 8'h10, read 8'h10 → `cpu_rd_valid` next cycle, data 8'h5A, `cpu_stall` never 1.
- Debug with idle CPU: `dbg_req` write 8'hC3 to 8'h20 → `dbg_gnt` 2 cycles later; CPU read of 8'h20 returns 8'hC3.
- Starvation: `cpu_req`=1 continuously, `dbg_req`=1 for 6 reads → debug granted after 8 CPU cycles; 4 grants; CPU stalls 4 cycles; remaining 2 reads granted after the next 8-cycle window.
- IO: CPU writes 8'h2A to 8'h01 → `io_out`=8'h2A with a 1-cycle `io_out_valid`; memory[8'h01]=8'h2A.
- Reset mid-burst: rst=0 during the 2nd debug write → write not performed; owner=`OWN_CPU`; no `rd_valid` after reset.
